tree_node_dispatch: RTL and testbench

Parametrised hierarchy node that fans one upstream request stream out to `NUM_CHILDREN` child ports. It generalises the fixed ten-child generated node: channel count and data width are parameters, and the node has real transport behaviour. That behaviour is a one-stage holding register, valid/ready handshakes, per-child outstanding-credit tracking and completion accounting. It sits between a parent node, or the top-level request source, and a row of child blocks.

---
 rtl/tree_node_pkg.sv | 16 +
 rtl/tree_node_dispatch_if.sv | 32 +++
 rtl/tree_node_credit.sv | 42 ++++
 rtl/tree_node_dispatch.sv | 132 +++++++++++++
 tb/tb_tree_node_dispatch.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/tree_node_pkg.sv
// Shared types and constants for the tree_node_dispatch hierarchy node.
package tree_node_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } tree_node_state_e;

  localparam int CNT_W = 4;

  // Index width for a child select; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/tree_node_dispatch_if.sv
// Upstream request, child fan-out and status bundle of one tree_node_dispatch node.
interface tree_node_dispatch_if #(
  parameter int NUM_CHILDREN = 10,
  parameter int DATA_W       = 32
);
  localparam int IDX_W = tree_node_pkg::idx_w(NUM_CHILDREN);
  localparam int CNT_W = tree_node_pkg::CNT_W;

  logic                          in_valid;
  logic                          in_ready;
  logic [DATA_W-1:0]             in_data;
  logic [IDX_W-1:0]              in_dest;
  logic [NUM_CHILDREN-1:0]       out_valid;
  logic [NUM_CHILDREN-1:0]       out_ready;
  logic [DATA_W-1:0]             out_data;
  logic [NUM_CHILDREN-1:0]       child_done;
  logic [NUM_CHILDREN*CNT_W-1:0] outstanding;
  logic                          busy;
  logic                          err_dest;
  logic                          err_underflow;

  modport master (
    output in_valid, in_data, in_dest, out_ready, child_done,
    input  in_ready, out_valid, out_data, outstanding, busy, err_dest, err_underflow
  );

  modport slave (
    input  in_valid, in_data, in_dest, out_ready, child_done,
    output in_ready, out_valid, out_data, outstanding, busy, err_dest, err_underflow
  );

endinterface

// File: rtl/tree_node_credit.sv
// Per-child in-flight counter: +1 on handshake, -1 on completion, with full flag
// and an underflow pulse when a completion arrives at count zero.
module tree_node_credit
  import tree_node_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_i,
  input  logic             dec_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             full_o,
  output logic             underflow_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // NOTE: every signal written in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    cnt_d       = cnt_q;
    underflow_o = 1'b0;
    unique case ({inc_i, dec_i})
      2'b10: if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
      2'b01: begin
        if (cnt_q == '0) underflow_o = 1'b1;
        else             cnt_d = cnt_q - CNT_W'(1);
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt_o  = cnt_q;
  assign full_o = (cnt_q >= CNT_W'(MAX_OUTSTANDING));

endmodule

// File: rtl/tree_node_dispatch.sv
// Hierarchy node: one-stage holding register fanning a request stream out to
// NUM_CHILDREN credit-limited children. Define TREE_NODE_RR_MODE_EN for round-robin dispatch.
module tree_node_dispatch
  import tree_node_pkg::*;
#(
  parameter int NUM_CHILDREN    = 10,
  parameter int DATA_W          = 32,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  tree_node_dispatch_if.slave  bus
);

  localparam int IDX_W = idx_w(NUM_CHILDREN);

  tree_node_state_e              state_q, state_d;
  logic [IDX_W-1:0]              dest_q, dest_d, load_dest;
  logic [DATA_W-1:0]             data_q, data_d;
  logic                          err_dest_q, err_dest_d;
  logic                          err_uf_q, err_uf_d;
  logic [NUM_CHILDREN-1:0]       full, inc, underflow, valid_vec;
  logic [NUM_CHILDREN*CNT_W-1:0] cnt_flat;
  logic                          handshake, accept, in_ready, dest_ok;

  for (genvar i = 0; i < NUM_CHILDREN; i++) begin : g_child
    tree_node_credit #(
      .MAX_OUTSTANDING(MAX_OUTSTANDING)
    ) u_credit (
      .clk        (clk),
      .rst        (rst),
      .inc_i      (inc[i]),
      .dec_i      (bus.child_done[i]),
      .cnt_o      (cnt_flat[i*CNT_W +: CNT_W]),
      .full_o     (full[i]),
      .underflow_o(underflow[i])
    );
  end

  // A held request is offered only while its child has credit left.
  always_comb begin
    valid_vec = '0;
    if (state_q == HOLD) valid_vec[dest_q] = ~full[dest_q];
  end

  assign inc       = valid_vec & bus.out_ready;
  assign handshake = |inc;

`ifdef TREE_NODE_RR_MODE_EN
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d, rr_pick;
  logic             unused_dest;
  int               rr_idx;

  assign unused_dest = ^bus.in_dest;

  // First non-full child after the last-served one, wrapping around.
  always_comb begin
    rr_pick = rr_ptr_q;
    rr_idx  = 0;
    for (int k = NUM_CHILDREN; k >= 1; k--) begin
      rr_idx = int'(rr_ptr_q) + k;
      if (rr_idx >= NUM_CHILDREN) rr_idx = rr_idx - NUM_CHILDREN;
      if (!full[IDX_W'(rr_idx)]) rr_pick = IDX_W'(rr_idx);
    end
  end
`endif

  always_comb begin
    state_d    = state_q;
    dest_d     = dest_q;
    data_d     = data_q;
    err_dest_d = 1'b0;
    in_ready   = (state_q == IDLE) || handshake;
`ifdef TREE_NODE_RR_MODE_EN
    rr_ptr_d   = rr_ptr_q;
    in_ready   = in_ready && !(&full);
    dest_ok    = 1'b1;
    load_dest  = rr_pick;
`else
    dest_ok    = int'(bus.in_dest) < NUM_CHILDREN;
    load_dest  = bus.in_dest;
`endif
    accept = bus.in_valid && in_ready;

    if (handshake) state_d = IDLE;
    if (accept) begin
      if (dest_ok) begin
        state_d = HOLD;
        dest_d  = load_dest;
        data_d  = bus.in_data;
`ifdef TREE_NODE_RR_MODE_EN
        rr_ptr_d = load_dest;
`endif
      end else begin
        err_dest_d = 1'b1;
      end
    end

    err_uf_d = err_uf_q || (|underflow);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      dest_q     <= '0;
      data_q     <= '0;
      err_dest_q <= 1'b0;
      err_uf_q   <= 1'b0;
`ifdef TREE_NODE_RR_MODE_EN
      rr_ptr_q   <= IDX_W'(NUM_CHILDREN - 1);
`endif
    end else begin
      state_q    <= state_d;
      dest_q     <= dest_d;
      data_q     <= data_d;
      err_dest_q <= err_dest_d;
      err_uf_q   <= err_uf_d;
`ifdef TREE_NODE_RR_MODE_EN
      rr_ptr_q   <= rr_ptr_d;
`endif
    end
  end

  assign bus.in_ready      = in_ready;
  assign bus.out_valid     = valid_vec;
  assign bus.out_data      = data_q;
  assign bus.outstanding   = cnt_flat;
  assign bus.busy          = (state_q == HOLD) || (|cnt_flat);
  assign bus.err_dest      = err_dest_q;
  assign bus.err_underflow = err_uf_q;

endmodule

// File: tb/tb_tree_node_dispatch.sv
// Directed bench for tree_node_dispatch (10 children, 32-bit data, 4 credits).
module tb_tree_node_dispatch;

  localparam int N  = 10;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vecs = 0;
  int   errs = 0;

  always #5 clk = ~clk;

  tree_node_dispatch_if #(.NUM_CHILDREN(N), .DATA_W(DW)) bus ();

  tree_node_dispatch #(
    .NUM_CHILDREN(N), .DATA_W(DW), .MAX_OUTSTANDING(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  function automatic logic [N*4-1:0] cnt_at(input int child, input int val);
    logic [N*4-1:0] v;
    v = '0;
    v[child*4 +: 4] = 4'(val);
    return v;
  endfunction

  function automatic logic [N-1:0] oh(input int child);
    logic [N-1:0] v;
    v = '0;
    v[child] = 1'b1;
    return v;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    vecs++; if (bus.in_ready !== 1'b1) begin errs++; $display("FAIL rst_in_ready: got %b want 1", bus.in_ready); end
    vecs++; if (bus.out_valid !== '0) begin errs++; $display("FAIL rst_out_valid: got %h want 0", bus.out_valid); end
    vecs++; if (bus.out_data !== '0) begin errs++; $display("FAIL rst_out_data: got %h want 0", bus.out_data); end
    vecs++; if (bus.outstanding !== '0) begin errs++; $display("FAIL rst_outstanding: got %h want 0", bus.outstanding); end
    vecs++; if (bus.busy !== 1'b0) begin errs++; $display("FAIL rst_busy: got %b want 0", bus.busy); end
    vecs++; if (bus.err_dest !== 1'b0) begin errs++; $display("FAIL rst_err_dest: got %b want 0", bus.err_dest); end
    vecs++; if (bus.err_underflow !== 1'b0) begin errs++; $display("FAIL rst_err_underflow: got %b want 0", bus.err_underflow); end
    rst = 1'b0;
  endtask

`ifndef TREE_NODE_RR_MODE_EN
  task automatic test_single();
    bus.in_valid  = 1'b1;
    bus.in_dest   = 4'd3;
    bus.in_data   = 32'hA5A5_0001;
    bus.out_ready = oh(3);
    #1;
    vecs++; if (bus.in_ready !== 1'b1) begin errs++; $display("FAIL single_in_ready: got %b want 1", bus.in_ready); end
    @(negedge clk);
    bus.in_valid = 1'b0;
    vecs++; if (bus.out_valid !== oh(3)) begin errs++; $display("FAIL single_valid: got %h want %h", bus.out_valid, oh(3)); end
    vecs++; if (bus.out_data !== 32'hA5A5_0001) begin errs++; $display("FAIL single_data: got %h want a5a50001", bus.out_data); end
    vecs++; if (bus.outstanding !== '0) begin errs++; $display("FAIL single_cnt_pre: got %h want 0", bus.outstanding); end
    @(negedge clk);
    vecs++; if (bus.out_valid !== '0) begin errs++; $display("FAIL single_valid_after: got %h want 0", bus.out_valid); end
    vecs++; if (bus.outstanding !== cnt_at(3, 1)) begin errs++; $display("FAIL single_cnt_post: got %h want %h", bus.outstanding, cnt_at(3, 1)); end
    vecs++; if (bus.busy !== 1'b1) begin errs++; $display("FAIL single_busy: got %b want 1", bus.busy); end
    bus.out_ready  = '0;
    bus.child_done = oh(3);
    @(negedge clk);
    bus.child_done = '0;
    vecs++; if (bus.outstanding !== '0) begin errs++; $display("FAIL single_done: got %h want 0", bus.outstanding); end
    vecs++; if (bus.busy !== 1'b0) begin errs++; $display("FAIL single_idle_busy: got %b want 0", bus.busy); end
  endtask

  task automatic test_credit_stall();
    bus.out_ready = oh(7);
    bus.in_dest   = 4'd7;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) begin
        vecs++; if (bus.out_valid !== oh(7)) begin errs++; $display("FAIL stall_valid_%0d: got %h want %h", i, bus.out_valid, oh(7)); end
        vecs++; if (bus.out_data !== 32'h7000 + 32'(i - 1)) begin errs++; $display("FAIL stall_data_%0d: got %h want %h", i, bus.out_data, 32'h7000 + 32'(i - 1)); end
      end
      bus.in_valid = 1'b1;
      bus.in_data  = 32'h7000 + 32'(i);
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    #1;
    vecs++; if (bus.out_valid !== '0) begin errs++; $display("FAIL stall_blocked: got %h want 0", bus.out_valid); end
    vecs++; if (bus.outstanding !== cnt_at(7, 4)) begin errs++; $display("FAIL stall_cnt: got %h want %h", bus.outstanding, cnt_at(7, 4)); end
    vecs++; if (bus.in_ready !== 1'b0) begin errs++; $display("FAIL stall_in_ready: got %b want 0", bus.in_ready); end
    vecs++; if (bus.out_data !== 32'h7004) begin errs++; $display("FAIL stall_held_data: got %h want 00007004", bus.out_data); end
    bus.child_done = oh(7);
    @(negedge clk);
    bus.child_done = '0;
    vecs++; if (bus.out_valid !== oh(7)) begin errs++; $display("FAIL stall_release: got %h want %h", bus.out_valid, oh(7)); end
    vecs++; if (bus.outstanding !== cnt_at(7, 3)) begin errs++; $display("FAIL stall_freed: got %h want %h", bus.outstanding, cnt_at(7, 3)); end
    @(negedge clk);
    vecs++; if (bus.outstanding !== cnt_at(7, 4)) begin errs++; $display("FAIL stall_refill: got %h want %h", bus.outstanding, cnt_at(7, 4)); end
    vecs++; if (bus.out_valid !== '0) begin errs++; $display("FAIL stall_drained: got %h want 0", bus.out_valid); end
    bus.out_ready  = '0;
    bus.child_done = oh(7);
    repeat (4) @(negedge clk);
    bus.child_done = '0;
    vecs++; if (bus.outstanding !== '0) begin errs++; $display("FAIL stall_cleanup: got %h want 0", bus.outstanding); end
  endtask

  task automatic test_same_cycle();
    bus.out_ready = oh(2);
    bus.in_dest   = 4'd2;
    bus.in_valid  = 1'b1;
    bus.in_data   = 32'h2222_0000;
    repeat (3) @(negedge clk);
    bus.in_valid   = 1'b0;
    bus.child_done = oh(2);
    #1;
    vecs++; if (bus.outstanding !== cnt_at(2, 2)) begin errs++; $display("FAIL same_pre: got %h want %h", bus.outstanding, cnt_at(2, 2)); end
    vecs++; if (bus.out_valid !== oh(2)) begin errs++; $display("FAIL same_valid: got %h want %h", bus.out_valid, oh(2)); end
    @(negedge clk);
    vecs++; if (bus.outstanding !== cnt_at(2, 2)) begin errs++; $display("FAIL same_cnt: got %h want %h", bus.outstanding, cnt_at(2, 2)); end
    vecs++; if (bus.err_underflow !== 1'b0) begin errs++; $display("FAIL same_no_uf: got %b want 0", bus.err_underflow); end
    bus.child_done = oh(5);
    @(negedge clk);
    bus.child_done = '0;
    vecs++; if (bus.err_underflow !== 1'b1) begin errs++; $display("FAIL uf_set: got %b want 1", bus.err_underflow); end
    vecs++; if (bus.outstanding !== cnt_at(2, 2)) begin errs++; $display("FAIL uf_cnt: got %h want %h", bus.outstanding, cnt_at(2, 2)); end
    repeat (3) @(negedge clk);
    vecs++; if (bus.err_underflow !== 1'b1) begin errs++; $display("FAIL uf_sticky: got %b want 1", bus.err_underflow); end
    bus.out_ready  = '0;
    bus.child_done = oh(2);
    repeat (2) @(negedge clk);
    bus.child_done = '0;
    vecs++; if (bus.outstanding !== '0) begin errs++; $display("FAIL same_cleanup: got %h want 0", bus.outstanding); end
  endtask

  task automatic test_bad_dest();
    bus.out_ready = '1;
    bus.in_valid  = 1'b1;
    bus.in_dest   = 4'd12;
    bus.in_data   = 32'hBAD0_000C;
    #1;
    vecs++; if (bus.in_ready !== 1'b1) begin errs++; $display("FAIL bad_in_ready: got %b want 1", bus.in_ready); end
    @(negedge clk);
    bus.in_valid = 1'b0;
    vecs++; if (bus.err_dest !== 1'b1) begin errs++; $display("FAIL bad_err: got %b want 1", bus.err_dest); end
    vecs++; if (bus.out_valid !== '0) begin errs++; $display("FAIL bad_valid: got %h want 0", bus.out_valid); end
    vecs++; if (bus.busy !== 1'b0) begin errs++; $display("FAIL bad_busy: got %b want 0", bus.busy); end
    @(negedge clk);
    vecs++; if (bus.err_dest !== 1'b0) begin errs++; $display("FAIL bad_pulse: got %b want 0", bus.err_dest); end
    vecs++; if (bus.out_valid !== '0) begin errs++; $display("FAIL bad_valid2: got %h want 0", bus.out_valid); end
  endtask

  task automatic test_reset_mid();
    bus.out_ready = oh(0);
    bus.in_valid  = 1'b1;
    bus.in_dest   = 4'd0;
    bus.in_data   = 32'h0000_00AA;
    @(negedge clk);
    bus.in_dest   = 4'd1;
    bus.in_data   = 32'h0000_00BB;
    @(negedge clk);
    bus.in_valid = 1'b0;
    vecs++; if (bus.out_valid !== oh(1)) begin errs++; $display("FAIL mid_hold: got %h want %h", bus.out_valid, oh(1)); end
    vecs++; if (bus.outstanding !== cnt_at(0, 1)) begin errs++; $display("FAIL mid_cnt: got %h want %h", bus.outstanding, cnt_at(0, 1)); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.out_ready = '0;
    vecs++; if (bus.out_valid !== '0) begin errs++; $display("FAIL mid_valid: got %h want 0", bus.out_valid); end
    vecs++; if (bus.outstanding !== '0) begin errs++; $display("FAIL mid_zero: got %h want 0", bus.outstanding); end
    vecs++; if (bus.busy !== 1'b0) begin errs++; $display("FAIL mid_busy: got %b want 0", bus.busy); end
    vecs++; if (bus.err_underflow !== 1'b0) begin errs++; $display("FAIL mid_uf_clear: got %b want 0", bus.err_underflow); end
  endtask
`else
  task automatic test_round_robin();
    bus.out_ready = '1;
    for (int i = 0; i <= 12; i++) begin
      if (i > 0) begin
        vecs++; if (bus.out_valid !== oh((i - 1) % N)) begin errs++; $display("FAIL rr_%0d: got %h want %h", i, bus.out_valid, oh((i - 1) % N)); end
      end
      bus.in_valid = (i < 12);
      bus.in_data  = 32'hC000 + 32'(i);
      @(negedge clk);
    end
    vecs++; if (bus.err_dest !== 1'b0) begin errs++; $display("FAIL rr_err_dest: got %b want 0", bus.err_dest); end
    vecs++; if (bus.outstanding !== {4'd1,4'd1,4'd1,4'd1,4'd1,4'd1,4'd1,4'd1,4'd2,4'd2}) begin
      errs++; $display("FAIL rr_counts: got %h want 1111111122", bus.outstanding);
    end
    bus.out_ready = '0;
    bus.in_valid  = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    vecs++; if (bus.out_valid !== oh(2)) begin errs++; $display("FAIL rr_hold: got %h want %h", bus.out_valid, oh(2)); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    vecs++; if (bus.out_valid !== '0) begin errs++; $display("FAIL rr_rst_valid: got %h want 0", bus.out_valid); end
    vecs++; if (bus.outstanding !== '0) begin errs++; $display("FAIL rr_rst_cnt: got %h want 0", bus.outstanding); end
  endtask
`endif

  initial begin
    bus.in_valid   = 1'b0;
    bus.in_data    = '0;
    bus.in_dest    = '0;
    bus.out_ready  = '0;
    bus.child_done = '0;
    test_reset();
`ifndef TREE_NODE_RR_MODE_EN
    test_single();
    test_credit_stall();
    test_same_cycle();
    test_bad_dest();
    test_reset_mid();
`else
    test_round_robin();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
